dispctl_parm: RTL

Parametrised successor to the fixed 8-digit seven-segment display controller. It scans NDIG hex digits onto a time-multiplexed, common-anode, active-low display.
- Refresh rate is derived from CLKFREQ, so no external enable is needed.
- Adds global PWM brightness, per-digit blanking, per-digit blink and leading-zero blanking.
- Sits between the top-level board wrapper and the display pins; all outputs are registered.

---
 rtl/dispctl_pkg.sv | 36 +++
 rtl/dispctl_tickgen.sv | 29 ++
 rtl/dispctl_parm.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dispctl_pkg.sv
// rtl/dispctl_pkg.sv - shared constants and helpers for the parametrised display controller
package dispctl_pkg;

    // All segments dark (active-low)
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex font, active-low, bit 0 = segment a .. bit 6 = segment g
    function automatic logic [6:0] hex2seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Width of the digit index; a single-digit display still needs one bit
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dispctl_tickgen.sv
// rtl/dispctl_tickgen.sv - free-running divider producing a one-cycle pulse every DIV clocks
module dispctl_tickgen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV <= 1) ? 1 : $clog2(DIV);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(DIV - 1));
    assign tick   = w_last;

    // Count 0..DIV-1 and wrap; the pulse is the terminal count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dispctl_parm.sv
// rtl/dispctl_parm.sv - multiplexed seven-segment scanner with PWM, blanking, blink and LZ blanking
module dispctl_parm #(
    parameter int NDIG     = 8,
    parameter int CLKFREQ  = 100_000_000,
    parameter int DIGFREQ  = 1000,
    parameter int BRIGHT_W = 4,
    parameter int BLINK_HZ = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*NDIG-1:0]     digits,
    input  logic [NDIG-1:0]       dp_in,
    input  logic [NDIG-1:0]       blank,
    input  logic [NDIG-1:0]       blink,
    input  logic                  lzb,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NDIG-1:0]       an
);

    import dispctl_pkg::*;

    localparam int SEL_W    = sel_width(NDIG);
    localparam int PWM_STEP = DIGFREQ * (2 ** BRIGHT_W);
    localparam int SUB_DIV  = CLKFREQ / PWM_STEP;
    localparam int BLK_DIV  = CLKFREQ / (2 * BLINK_HZ);

    // Refuse to build with rates that do not divide the clock exactly
    if ((CLKFREQ % PWM_STEP) != 0 || (CLKFREQ % (2 * BLINK_HZ)) != 0) begin : g_bad_div
        $fatal(1, "dispctl_parm: CLKFREQ not divisible by scan or blink rate");
    end
    if (NDIG < 1 || NDIG > 16) begin : g_bad_ndig
        $fatal(1, "dispctl_parm: NDIG out of range 1..16");
    end

    logic                w_sub_tick;
    logic                w_blk_tick;
    logic [BRIGHT_W-1:0] r_pcnt;
    logic [SEL_W-1:0]    r_sel;
    logic                r_phase;
    logic [NDIG-1:0]     r_an;
    logic [6:0]          r_seg;
    logic                r_dp;

    logic [NDIG-1:0]     w_lz;
    logic                w_zero_run;
    logic [3:0]          w_cur_dig;
    logic                w_cur_blank;
    logic                w_cur_blink;
    logic                w_cur_dp;
    logic                w_cur_lz;
    logic [NDIG-1:0]     w_an_sel;
    logic                w_dark;

    dispctl_tickgen #(.DIV(SUB_DIV)) u_sub_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_sub_tick)
    );

    dispctl_tickgen #(.DIV(BLK_DIV)) u_blk_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_blk_tick)
    );

    // PWM step counter; the digit index advances each time it wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pcnt <= '0;
            r_sel  <= '0;
        end else if (w_sub_tick) begin
            r_pcnt <= r_pcnt + 1'b1;
            if (r_pcnt == {BRIGHT_W{1'b1}}) begin
                r_sel <= (r_sel == SEL_W'(NDIG - 1)) ? '0 : r_sel + 1'b1;
            end
        end
    end

    // Blink phase runs on its own divider, unrelated to the scan position
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= 1'b1;
        end else if (w_blk_tick) begin
            r_phase <= ~r_phase;
        end
    end

    // A digit is a leading zero when it and every digit above it is zero
    always_comb begin
        w_lz       = '0;
        w_zero_run = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run & (digits[4*i +: 4] == 4'h0);
            if (i != 0) begin
                w_lz[i] = lzb & w_zero_run;
            end
        end
    end

    // Pick out the attributes of the digit currently being scanned
    always_comb begin
        w_cur_dig   = 4'h0;
        w_cur_blank = 1'b0;
        w_cur_blink = 1'b0;
        w_cur_dp    = 1'b0;
        w_cur_lz    = 1'b0;
        w_an_sel    = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_cur_dig   = digits[4*i +: 4];
                w_cur_blank = blank[i];
                w_cur_blink = blink[i];
                w_cur_dp    = dp_in[i];
                w_cur_lz    = w_lz[i];
                w_an_sel[i] = 1'b0;
            end
        end
        w_dark = w_cur_blank | (w_cur_blink & ~r_phase) | (r_pcnt > bright);
    end

    // Register anodes, segments and dp together so they switch on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an  <= '1;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else if (w_dark) begin
            r_an  <= '1;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_sel;
            r_seg <= w_cur_lz ? SEG_OFF : hex2seg(w_cur_dig);
            r_dp  <= ~w_cur_dp;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
